// File: rtl/controller_pulse_out.sv
// Avalon-MM output PIO generating timed pulse bursts on out_port with a maskable done irq.
// Optional external start input enabled by CONTROLLER_PULSE_OUT_TRIGGER_EN.
module controller_pulse_out #(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
`ifdef CONTROLLER_PULSE_OUT_TRIGGER_EN
  ,
  input  logic        trig_in
`endif
);

  // state  | meaning
  // S_IDLE   | out_port follows idle level, waiting for COUNT write or trigger
  // S_ACTIVE | driving the active level for the high-phase length
  // S_GAP    | driving the idle level between pulses
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

  localparam logic [2:0] A_IDLE   = 3'd0;
  localparam logic [2:0] A_HIGH   = 3'd1;
  localparam logic [2:0] A_LOW    = 3'd2;
  localparam logic [2:0] A_COUNT  = 3'd3;
  localparam logic [2:0] A_CTRL   = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;

  state_t           state;
  logic             idle_lvl;
  logic [LEN_W-1:0] high_len;
  logic [LEN_W-1:0] low_len;
  logic [LEN_W-1:0] ctr;
  logic [15:0]      reload;
  logic [15:0]      remaining;
  logic             irq_mask;
  logic             done;

  logic wr_en, wr_idle, wr_high, wr_low, wr_count, wr_ctrl, wr_status;
  logic abort, count_start, trig_rise, trig_lvl, start_req, busy;
  logic [15:0]      start_val;
  logic [LEN_W-1:0] high_eff, low_eff;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wr_idle   = wr_en && (address == A_IDLE);
  assign wr_high   = wr_en && (address == A_HIGH);
  assign wr_low    = wr_en && (address == A_LOW);
  assign wr_count  = wr_en && (address == A_COUNT);
  assign wr_ctrl   = wr_en && (address == A_CTRL);
  assign wr_status = wr_en && (address == A_STATUS);
  assign abort     = wr_ctrl & writedata[31];
  assign unused_wd = ^writedata;

  assign count_start = wr_count && (writedata[15:0] != 16'd0);
  assign start_req   = count_start | (trig_rise & ~wr_count & (|reload));
  assign start_val   = wr_count ? writedata[15:0] : reload;
  assign high_eff    = (high_len == '0) ? LEN_W'(1) : high_len;
  assign low_eff     = (low_len == '0) ? LEN_W'(1) : low_len;
  assign busy        = (state != S_IDLE);
  assign irq         = done & irq_mask;

`ifdef CONTROLLER_PULSE_OUT_TRIGGER_EN
  // trig_meta/trig_d1 form the synchronizer; trig_d2 is edge-detect history
  logic trig_meta, trig_d1, trig_d2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_meta <= 1'b0;
      trig_d1   <= 1'b0;
      trig_d2   <= 1'b0;
    end else begin
      trig_meta <= trig_in;
      trig_d1   <= trig_meta;
      trig_d2   <= trig_d1;
    end
  end

  assign trig_rise = trig_d1 & ~trig_d2;
  assign trig_lvl  = trig_d1;
`else
  assign trig_rise = 1'b0;
  assign trig_lvl  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      idle_lvl  <= 1'b0;
      high_len  <= LEN_W'(1);
      low_len   <= LEN_W'(1);
      ctr       <= '0;
      reload    <= 16'd0;
      remaining <= 16'd0;
      irq_mask  <= 1'b0;
      done      <= 1'b0;
      out_port  <= 1'b0;
    end else begin
      if (wr_idle)  idle_lvl <= writedata[0];
      if (wr_high)  high_len <= writedata[LEN_W-1:0];
      if (wr_low)   low_len  <= writedata[LEN_W-1:0];
      if (wr_count) reload   <= writedata[15:0];
      if (wr_ctrl)  irq_mask <= writedata[0];
      // a done set later in this block overrides the clear
      if (wr_status) done <= 1'b0;

      if (abort) begin
        state     <= S_IDLE;
        remaining <= 16'd0;
        out_port  <= idle_lvl;
      end else begin
        case (state)
          S_IDLE: begin
            out_port <= idle_lvl;
            if (start_req) begin
              state     <= S_ACTIVE;
              remaining <= start_val;
              ctr       <= high_eff;
              out_port  <= ~idle_lvl;
            end
          end
          S_ACTIVE: begin
            if (ctr == LEN_W'(1)) begin
              out_port <= idle_lvl;
              if (remaining > 16'd1) begin
                remaining <= remaining - 16'd1;
                ctr       <= low_eff;
                state     <= S_GAP;
              end else begin
                remaining <= 16'd0;
                state     <= S_IDLE;
                done      <= 1'b1;
              end
            end else begin
              ctr <= ctr - LEN_W'(1);
            end
          end
          S_GAP: begin
            if (ctr == LEN_W'(1)) begin
              ctr      <= high_eff;
              out_port <= ~idle_lvl;
              state    <= S_ACTIVE;
            end else begin
              ctr <= ctr - LEN_W'(1);
            end
          end
          default: begin
            state    <= S_IDLE;
            out_port <= idle_lvl;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else begin
      case (address)
        A_IDLE:   readdata <= {31'd0, idle_lvl};
        A_HIGH:   readdata <= {{(32-LEN_W){1'b0}}, high_len};
        A_LOW:    readdata <= {{(32-LEN_W){1'b0}}, low_len};
        A_COUNT:  readdata <= {16'd0, remaining};
        A_CTRL:   readdata <= {31'd0, irq_mask};
        A_STATUS: readdata <= {29'd0, trig_lvl, done, busy};
        default:  readdata <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_pulse_out.sv
// Scoreboard bench for controller_pulse_out: a burst-level reference model predicts the
// out_port waveform, irq and register reads; a negedge monitor pops and compares.
module tb_controller_pulse_out;
  localparam int LEN_W = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        out_port;
  logic        irq;
`ifdef CONTROLLER_PULSE_OUT_TRIGGER_EN
  logic        trig_in = 1'b0;
`endif

  controller_pulse_out #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .irq(irq)
`ifdef CONTROLLER_PULSE_OUT_TRIGGER_EN
    , .trig_in(trig_in)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model state: register images plus one burst described by its parameters
  bit               idle_exp = 1'b0;
  bit               mask_exp = 1'b0;
  logic [LEN_W-1:0] hlen_exp = 1;
  logic [LEN_W-1:0] llen_exp = 1;
  logic [15:0]      reload_exp = 16'd0;
  int b_start = -1, b_n = 0, b_h = 1, b_l = 1, b_end = -1;
  bit b_abort = 1'b0;
  int d_prev = -1, clr_edge = -1;

  typedef struct { int addr; logic [31:0] exp; } rd_t;
  bit  out_q[$];
  rd_t rd_q[$];

  function automatic bit m_busy(int e);
    return (b_start >= 0) && (e >= b_start) && (e < b_end);
  endfunction

  function automatic int m_rem(int e);
    int cnt = 0;
    if (!m_busy(e)) return 0;
    for (int j = 1; j < b_n; j++)
      if (b_start + j * b_h + (j - 1) * b_l <= e) cnt++;
    return b_n - cnt;
  endfunction

  function automatic bit m_done(int e);
    int d;
    d = (b_start >= 0 && !b_abort && b_end <= e) ? b_end : d_prev;
    return (d >= 0) && (d <= e) && !(clr_edge > d && clr_edge <= e);
  endfunction

  function automatic logic [31:0] exp_read(int a, int e);
    case (a)
      0: return {31'd0, idle_exp};
      1: return {16'd0, hlen_exp};
      2: return {16'd0, llen_exp};
      3: return 32'(m_rem(e));
      4: return {31'd0, mask_exp};
      5: return {30'd0, m_done(e), m_busy(e)};
      default: return 32'd0;
    endcase
  endfunction

  task automatic start_burst(input int e, input int n);
    if (b_start >= 0 && !b_abort) d_prev = b_end;
    b_start = e;
    b_n = n;
    b_h = (hlen_exp == 0) ? 1 : int'(hlen_exp);
    b_l = (llen_exp == 0) ? 1 : int'(llen_exp);
    b_end = e + n * b_h + (n - 1) * b_l;
    b_abort = 1'b0;
    out_q.delete();
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < b_h; k++) out_q.push_back(~idle_exp);
      if (j < n - 1)
        for (int k = 0; k < b_l; k++) out_q.push_back(idle_exp);
    end
  endtask

  task automatic model_reset();
    idle_exp = 0; mask_exp = 0; hlen_exp = 1; llen_exp = 1; reload_exp = 0;
    b_start = -1; b_end = -1; b_abort = 0; d_prev = -1; clr_edge = -1;
    out_q.delete();
    rd_q.delete();
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    int e_s;
    @(posedge clk); #1;
    address = 3'(a); chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    e_s = cyc;
    case (a)
      0: begin
        if (out_q.size() == 0) out_q.push_back(idle_exp);
        idle_exp = d[0];
      end
      1: hlen_exp = d[LEN_W-1:0];
      2: llen_exp = d[LEN_W-1:0];
      3: begin
        reload_exp = d[15:0];
        if (d[15:0] != 0 && !m_busy(e_s - 1)) start_burst(e_s, int'(d[15:0]));
      end
      4: begin
        mask_exp = d[0];
        if (d[31] && m_busy(e_s - 1)) begin
          b_end = e_s; b_abort = 1'b1;
          out_q.delete();
        end
      end
      5: clr_edge = e_s;
      default: ;
    endcase
  endtask

  task automatic rd(input int a);
    @(posedge clk); #1;
    address = 3'(a); chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0;
    rd_q.push_back('{a, exp_read(a, cyc - 1)});
  endtask

  task automatic wait_idle(input bit do_reads);
    int guard = 0;
    while (m_busy(cyc) && guard < 500) begin
      if (do_reads) rd($urandom_range(0, 5));
      else begin @(posedge clk); #1; end
      guard++;
    end
    if (guard >= 500) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: burst still running after %0d steps, required idle", guard);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      bit  e_o;
      rd_t r;
      if (out_q.size() > 0) e_o = out_q.pop_front();
      else e_o = idle_exp;
      check("out_port", {31'd0, out_port}, {31'd0, e_o});
      check("irq", {31'd0, irq}, {31'd0, m_done(cyc) & mask_exp});
      if (rd_q.size() > 0) begin
        r = rd_q.pop_front();
        check($sformatf("readdata[addr %0d]", r.addr), readdata, r.exp);
      end
    end
  end

  initial begin
    #12;
    check("reset out_port", {31'd0, out_port}, 32'd0);
    check("reset irq", {31'd0, irq}, 32'd0);
    check("reset readdata", readdata, 32'd0);
    #10 reset_n = 1'b1;
    rd(1); rd(5); rd(2); rd(0); rd(6);

    // H=3 L=2 N=3 with irq enabled, then clear done
    wr(4, 1); wr(1, 3); wr(2, 2); wr(3, 3);
    wait_idle(1);
    rd(5); wr(5, 0); rd(5);

    // inverted idle, 1-cycle single low pulse
    wr(0, 1); wr(1, 0); wr(3, 1);
    wait_idle(0);
    rd(3); rd(0);
    // remaining read while a longer burst runs
    wr(2, 3); wr(3, 4);
    rd(3); rd(3); rd(3);
    wait_idle(1);
    rd(3); wr(5, 0);

    // abort inside the first gap, COUNT write mid-burst ignored
    wr(0, 0); wr(1, 2); wr(2, 4); wr(3, 5);
    wr(3, 7);
    wr(4, 32'h8000_0001);
    rd(5); rd(3);
    repeat (4) begin @(posedge clk); #1; end

    // done set on the same edge as a STATUS write
    wr(1, 4); wr(2, 1); wr(3, 2);
    while (cyc < b_end - 2) begin @(posedge clk); #1; end
    wr(5, 0);
    rd(5);
    wr(5, 0);
    wr(3, 0); rd(5); rd(4);

    for (int i = 0; i < 12; i++) begin
      int h, l, n;
      bit lv, mk;
      h = $urandom_range(0, 4); l = $urandom_range(0, 4); n = $urandom_range(1, 4);
      lv = 1'($urandom_range(0, 1)); mk = 1'($urandom_range(0, 1));
      wr(5, 0); wr(0, {31'd0, lv}); wr(1, h); wr(2, l); wr(4, {31'd0, mk});
      wr(3, n);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 3)) rd($urandom_range(0, 5));
        wr(4, 32'h8000_0000 | {31'd0, mk});
      end else if ($urandom_range(0, 1) == 1) begin
        wr(3, $urandom_range(0, 9));
      end
      wait_idle(1);
      rd(5); rd(3);
    end

`ifdef CONTROLLER_PULSE_OUT_TRIGGER_EN
    wr(5, 0); wr(0, 0); wr(1, 2); wr(2, 1); wr(3, 2);
    wait_idle(0);
    @(posedge clk); #1; trig_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; trig_in = 1'b0;
    @(posedge clk); #1;
    if (!m_busy(cyc - 1)) start_burst(cyc, int'(reload_exp));
    @(posedge clk); #1; trig_in = 1'b1;
    wait_idle(0);
    trig_in = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rd(5); rd(3);
`endif

    // asynchronous reset in the middle of a burst
    wr(0, 0); wr(1, 5); wr(3, 3);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("async reset out_port", {31'd0, out_port}, 32'd0);
    check("async reset irq", {31'd0, irq}, 32'd0);
    check("async reset readdata", readdata, 32'd0);
    model_reset();
    @(posedge clk); #2;
    reset_n = 1'b1;
    rd(1); rd(3); rd(5);
    repeat (3) begin @(posedge clk); #1; end
    if (rd_q.size() != 0 || out_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard drain: %0d reads, %0d samples left, required 0", rd_q.size(), out_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
